// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared register-file types and constants. Used by the
//                writeback arbiter and, later, the memory-port arbiter.
//  Contents    : XLEN / REG_AW / NREG widths, ZERO_REG address, reg_adr_t
//                and xlen_t typedefs, is_zero_reg() helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef logic [REG_AW-1:0] reg_adr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    localparam reg_adr_t ZERO_REG = 5'd0;

    // x0 is hardwired to zero, so writes to it must never be enabled.
    function automatic logic is_zero_reg(input reg_adr_t adr);
        return (adr == ZERO_REG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback-requester bus plus register-file write port.
//  Signals     : req/req_adr/req_wd - per-requester request, destination,
//                                     data (requester side drives)
//                gnt                - one-hot grant (arbiter drives)
//                wa/wd/en           - registered register-file write port
//                ptr                - round-robin priority pointer (debug)
//  Modports    : master - requesters + register-file side
//                slave  - the arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) ();

    logic     [NREQ-1:0]          req;
    reg_adr_t [NREQ-1:0]          req_adr;
    xlen_t    [NREQ-1:0]          req_wd;
    logic     [NREQ-1:0]          gnt;
    reg_adr_t                     wa;
    xlen_t                        wd;
    logic                         en;
    logic     [$clog2(NREQ)-1:0]  ptr;

    modport master (
        output req, req_adr, req_wd,
        input  gnt, wa, wd, en, ptr
    );

    modport slave (
        input  req, req_adr, req_wd,
        output gnt, wa, wd, en, ptr
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The grant is combinational from the
//                requests and the priority pointer. The pointer moves to
//                one past the winner on every transfer.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                req_i  - request vector
//                gnt_o  - one-hot grant (zero while in reset)
//                xfer_o - a transfer happens at the next rising edge
//                win_o  - index of the granted requester
//                ptr_o  - current priority pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_i,
    output logic [N-1:0]          gnt_o,
    output logic                  xfer_o,
    output logic [$clog2(N)-1:0]  win_o,
    output logic [$clog2(N)-1:0]  ptr_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [N-1:0]  gnt_raw;
    logic          found;

    // Search PTR, PTR+1, ... with wrap at N; the first requester seen wins.
    always_comb begin
        gnt_raw = '0;
        found   = 1'b0;
        win_o   = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            idx = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                gnt_raw[idx] = 1'b1;
                win_o        = idx;
            end
        end
    end

    // The flops are held by the async reset, so only the visible grant needs
    // masking while reset is asserted.
    assign gnt_o  = rst_n ? gnt_raw : '0;
    assign xfer_o = found;
    assign ptr_o  = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (win_o == PW'(N-1)) ? '0 : win_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register file's single write port among NREQ
//                writeback requesters. Grants are round-robin, and the
//                winning write is registered before it reaches the register
//                file. Writes to x0 are consumed but never enabled.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset
//                bus   - requester bus and register-file write port (slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    regfile_wb_arbiter_if.slave       bus
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] gnt;
    logic            xfer;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr;

    reg_adr_t wa_q, wa_d;
    xlen_t    wd_q, wd_d;
    logic     en_q, en_d;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (bus.req),
        .gnt_o  (gnt),
        .xfer_o (xfer),
        .win_o  (win),
        .ptr_o  (ptr)
    );

    // Without a transfer WA/WD keep their last values; only EN drops.
    always_comb begin
        wa_d = wa_q;
        wd_d = wd_q;
        en_d = 1'b0;
        if (xfer) begin
            wa_d = bus.req_adr[win];
            wd_d = bus.req_wd[win];
            en_d = !is_zero_reg(bus.req_adr[win]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_q <= '0;
            wd_q <= '0;
            en_q <= 1'b0;
        end else begin
            wa_q <= wa_d;
            wd_q <= wd_d;
            en_q <= en_d;
        end
    end

    assign bus.gnt = gnt;
    assign bus.wa  = wa_q;
    assign bus.wd  = wd_q;
    assign bus.en  = en_q;
    assign bus.ptr = ptr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter. A behavioural
//                model (pointer as an integer, winner found by a modulo
//                search, register file as an array) predicts the grant, the
//                output stage and the register-file contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file driven by the DUT write port.
    xlen_t rf [NREG] = '{default: '0};
    always @(posedge clk) begin
        if (bus.en) rf[bus.wa] <= bus.wd;
    end

    // Reference model state.
    int       m_ptr = 0;
    logic     m_en  = 1'b0;
    reg_adr_t m_wa  = '0;
    xlen_t    m_wd  = '0;
    xlen_t    m_rf [NREG] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_port(input int i, input reg_adr_t a, input xlen_t d);
        bus.req_adr[i] = a;
        bus.req_wd[i]  = d;
    endtask

    task automatic chk_reg(input int a);
        chk($sformatf("x%0d", a), 64'(rf[a]), 64'(m_rf[a]));
    endtask

    // One clock: check grant mid-cycle, advance the model at the edge,
    // then check the output stage just after the edge.
    task automatic cycle(output int w);
        logic [NREQ-1:0] eg;
        @(negedge clk);
        w  = winner(bus.req, m_ptr);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 64'(bus.gnt), 64'(eg));
        @(posedge clk);
        if (m_en) m_rf[m_wa] = m_wd;
        if (w >= 0) begin
            m_wa  = bus.req_adr[w];
            m_wd  = bus.req_wd[w];
            m_en  = (bus.req_adr[w] != ZERO_REG);
            m_ptr = (w + 1) % NREQ;
        end else begin
            m_en = 1'b0;
        end
        #1;
        chk("en",  64'(bus.en),  64'(m_en));
        chk("wa",  64'(bus.wa),  64'(m_wa));
        chk("wd",  64'(bus.wd),  64'(m_wd));
        chk("ptr", 64'(bus.ptr), 64'(m_ptr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;

        // ---- Reset with all ports requesting ----
        bus.req = '1;
        for (int i = 0; i < NREQ; i++) set_port(i, reg_adr_t'(10 + i), xlen_t'(i));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_en",  64'(bus.en),  64'(0));
        chk("rst_wa",  64'(bus.wa),  64'(0));
        chk("rst_wd",  64'(bus.wd),  64'(0));
        chk("rst_ptr", 64'(bus.ptr), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- Full contention: rotating grants, WD 0,1,2,0,1,2 ----
        for (int k = 0; k < 6; k++) begin
            cycle(w);
            chk("cont_wd", 64'(bus.wd), 64'(k % 3));
            chk("cont_wa", 64'(bus.wa), 64'(10 + k % 3));
        end
        bus.req = 3'b011; cycle(w);
        bus.req = 3'b010; cycle(w);
        bus.req = 3'b000; cycle(w);

        // ---- Single write to x7 from port 1 ----
        set_port(1, 5'd7, 32'hDEADBEEF);
        bus.req = 3'b010;
        cycle(w);
        chk("single_en",  64'(bus.en),  64'(1));
        chk("single_wa",  64'(bus.wa),  64'(7));
        chk("single_wd",  64'(bus.wd),  64'(32'hDEADBEEF));
        chk("single_ptr", 64'(bus.ptr), 64'(2));
        bus.req = 3'b000;
        cycle(w);
        chk("single_x7", 64'(rf[7]), 64'(32'hDEADBEEF));

        // ---- x0 write from port 2 ----
        set_port(2, 5'd0, 32'h1234);
        bus.req = 3'b100;
        cycle(w);
        chk("x0_en",  64'(bus.en),  64'(0));
        chk("x0_ptr", 64'(bus.ptr), 64'(0));
        bus.req = 3'b000;
        cycle(w);
        chk("x0_rf", 64'(rf[0]), 64'(0));

        // ---- Same-address ordering: later grant wins ----
        set_port(0, 5'd5, 32'hA);
        set_port(1, 5'd5, 32'hB);
        bus.req = 3'b011; cycle(w);
        bus.req = 3'b010; cycle(w);
        bus.req = 3'b000; cycle(w);
        cycle(w);
        chk("order_x5", 64'(rf[5]), 64'(32'hB));

        // ---- Randomized traffic; ungranted requests are held ----
        w = -1;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] || w == i) begin
                    if ($urandom_range(0, 3) != 0) begin
                        bus.req[i] = 1'b1;
                        set_port(i, reg_adr_t'($urandom_range(0, 7)), xlen_t'($urandom));
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end
            end
            cycle(w);
            if (c % 50 == 49) begin
                for (int a = 0; a < 8; a++) chk_reg(a);
            end
        end
        if (w >= 0) bus.req[w] = 1'b0;
        for (int k = 0; k < 2 * NREQ; k++) begin
            if (bus.req != '0) begin
                cycle(w);
                if (w >= 0) bus.req[w] = 1'b0;
            end
        end
        cycle(w);
        cycle(w);
        for (int a = 0; a < 8; a++) chk_reg(a);

        // ---- Async reset while a write sits in the output stage ----
        set_port(0, 5'd9, 32'hCAFE0009);
        bus.req = 3'b001;
        cycle(w);
        chk("mid_en_before", 64'(bus.en), 64'(1));
        bus.req = 3'b111;
        for (int i = 0; i < NREQ; i++) set_port(i, reg_adr_t'(20 + i), xlen_t'(32'h100 + i));
        #2 rst_n = 1'b0;
        m_en = 1'b0; m_wa = '0; m_wd = '0; m_ptr = 0;
        #1;
        chk("mid_en",  64'(bus.en),  64'(0));
        chk("mid_wa",  64'(bus.wa),  64'(0));
        chk("mid_wd",  64'(bus.wd),  64'(0));
        chk("mid_ptr", 64'(bus.ptr), 64'(0));
        chk("mid_gnt", 64'(bus.gnt), 64'(0));
        @(posedge clk);
        #1;
        chk("mid_x9", 64'(rf[9]), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Arbitration restarts from port 0 after release.
        cycle(w);
        chk("post_wa", 64'(bus.wa), 64'(20));
        chk("post_wd", 64'(bus.wd), 64'(32'h100));
        bus.req = 3'b110; cycle(w);
        bus.req = 3'b100; cycle(w);
        bus.req = 3'b000; cycle(w);
        cycle(w);
        for (int a = 0; a < NREG; a++) chk_reg(a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
